// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, a single-entry
// buffer towards ID, redirect squashing. Optional timeout flag under FETCH_TIMEOUT_EN.
module fetch_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_id,
  input  logic        redirect,
  output logic        imem_req,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        pc_en,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic        fetch_err
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("fetch_ctrl: TIMEOUT_CYCLES must be within 2..255");
  end

  logic [1:0]  state_q, state_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        load;

  always_comb begin
    // Requests only when the buffer is free or being consumed this cycle.
    imem_req = ~rst & (state_q == ST_FETCH) & ~redirect & (~if_valid_q | ~stall_id);
    pc_en    = ~rst & (redirect | ((state_q == ST_WAIT) & imem_rvalid));
    load     = (state_q == ST_WAIT) & imem_rvalid & ~redirect;

    state_d = state_q;
    case (state_q)
      ST_FETCH: if (imem_req & imem_gnt) state_d = ST_WAIT;
      ST_WAIT: begin
        if (imem_rvalid)   state_d = ST_FETCH;
        else if (redirect) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (imem_rvalid) state_d = ST_FETCH;
      default:  state_d = ST_FETCH;
    endcase

    if (load)                      if_valid_d = 1'b1;
    else if (redirect | ~stall_id) if_valid_d = 1'b0;
    else                           if_valid_d = if_valid_q;

    if_instr_d = load ? imem_rdata : if_instr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      if_valid_q <= 1'b0;
      if_instr_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
    end
  end

  assign if_valid = if_valid_q;
  assign if_instr = if_instr_q;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic       fetch_err_q, fetch_err_d;

  always_comb begin
    // Counts consecutive waiting cycles; any response ends the wait.
    tmo_cnt_d = tmo_cnt_q;
    if ((state_q == ST_FETCH) | imem_rvalid) tmo_cnt_d = 8'h0;
    else if (tmo_cnt_q != 8'hFF)             tmo_cnt_d = tmo_cnt_q + 8'h1;
    fetch_err_d = fetch_err_q | (tmo_cnt_d == TMO_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q   <= 8'h0;
      fetch_err_q <= 1'b0;
    end else begin
      tmo_cnt_q   <= tmo_cnt_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign fetch_err = fetch_err_q;
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning max cycles awaiting imem_rvalid before fetch_err (range 2..255).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port stall_id  input  1  decode cannot accept the buffered instruction this cycle.
REQ-005 SHALL have port redirect  input  1  taken jump/branch resolved in ID; PC register loads target when pc_en=1.
REQ-006 SHALL have port imem_req  output  1  fetch request at current PC.
REQ-007 SHALL have port imem_gnt  input  1  memory accepts request; meaningful only while imem_req=1.
REQ-008 SHALL have port imem_rvalid  input  1  response data valid, exactly one per granted request, arbitrary latency >=1 cycle, no backpressure.
REQ-009 SHALL have port imem_rdata  input  32  response instruction word.
REQ-010 SHALL have port pc_en  output  1  enable to the PC register (PC+4 or redirect target).
REQ-011 SHALL have port if_valid  output  1  if_instr holds a valid instruction for ID.
REQ-012 SHALL have port if_instr  output  32  buffered instruction to ID.
REQ-013 SHALL have port fetch_err  output  1  sticky memory-timeout flag.

Function
REQ-014 SHALL implement FSM states FETCH, WAIT, DRAIN; at most one request outstanding.
REQ-015 SHALL drive imem_req combinationally = (state==FETCH) & ~redirect & (~if_valid | ~stall_id); withdrawal of imem_req before imem_gnt is legal.
REQ-016 SHALL go FETCH->WAIT on imem_req & imem_gnt; otherwise remain in FETCH.
REQ-017 SHALL, in WAIT with imem_rvalid & ~redirect, load if_instr<=imem_rdata, set if_valid<=1, assert pc_en combinationally that cycle, go to FETCH.
REQ-018 SHALL, in WAIT with redirect & ~imem_rvalid, assert pc_en that cycle and go to DRAIN.
REQ-019 SHALL, in WAIT with redirect & imem_rvalid same cycle, discard imem_rdata, assert pc_en, go to FETCH.
REQ-020 SHALL, in DRAIN, discard the response when imem_rvalid=1 and go to FETCH; pc_en=0 and buffer unchanged by the discard; a redirect in DRAIN asserts pc_en and stays in DRAIN.
REQ-021 SHALL, in FETCH with redirect, assert pc_en and remain in FETCH with no request that cycle.
REQ-022 SHALL treat redirect as squashing all younger work (no delay slot): if_valid<=0 the next cycle regardless of stall_id.
REQ-023 SHALL clear if_valid when if_valid & ~stall_id & no load that cycle; if_instr retains its last value when not loaded.
REQ-024 SHALL guarantee load and consume never coincide: REQ-015 ensures the buffer is empty when any non-discarded response arrives.
REQ-025 SHALL assert pc_en only in the cases of REQ-017 to REQ-021, for exactly one cycle per event; redirect has priority over all other conditions.
REQ-026 SHALL sustain one instruction per two cycles minimum with single-cycle memory and stall_id=0.

Reset
REQ-027 SHALL, while rst=1, force state FETCH, if_valid=0, if_instr=0, fetch_err=0, timeout counter=0, and imem_req=0, pc_en=0.
REQ-028 SHALL, on rst mid-operation, abandon any outstanding request; the memory subsystem is reset by the same rst.
REQ-029 SHALL issue the first request in the first cycle after rst deasserts.

Configuration
REQ-030 SHALL, with macro FETCH_TIMEOUT_EN defined, include an 8-bit saturating counter incremented each cycle in WAIT or DRAIN without imem_rvalid and cleared on leaving them, setting fetch_err=1 (sticky until rst) when the counter reaches TIMEOUT_CYCLES; FSM behaviour is unaffected.
REQ-031 SHALL, without FETCH_TIMEOUT_EN, omit the counter and tie fetch_err to 0.

Verification
REQ-032 SHALL cover: gnt=1 every cycle, rvalid 1 cycle after gnt, stall_id=0, words 0x24080001,0x24090002 -> if_valid pulses with those words in order, pc_en once per word.
REQ-033 SHALL cover: stall_id=1 held 5 cycles with if_valid=1 -> if_instr stable, imem_req=0, pc_en=0 throughout; release -> imem_req=1 same cycle.
REQ-034 SHALL cover: redirect in WAIT, rvalid 3 cycles later with 0xDEADBEEF -> pc_en exactly once at redirect, 0xDEADBEEF never appears with if_valid=1.
REQ-035 SHALL cover: redirect and rvalid same cycle -> data discarded, pc_en=1 once, next cycle state FETCH with imem_req=1.
REQ-036 SHALL cover: FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=16, rvalid withheld 20 cycles -> fetch_err=1 from 16th waiting cycle, stays 1 after response until rst.
REQ-037 SHALL cover: rst asserted in WAIT -> next cycle if_valid=0, fetch_err=0, state FETCH; first request the cycle after rst deasserts.
